// File: rtl/zap_wb_walk_arb.sv
// ---------------------------------------------------------------------------
// zap_wb_walk_arb
// Two-master Wishbone arbiter that sits between the MMU page-walker
// (master 0, read-only, highest priority) and the cache FSM (master 1) and a
// single Wishbone slave port. Masters present "next-cycle" request fields;
// the granted master's fields are registered straight onto the bus so that
// arbitration adds no latency. A stall watchdog aborts a transfer whose
// strobe goes unanswered for WDT_CYCLES cycles.
//
// Ports
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_m0_*_nxt                page-walker next-cycle cyc/stb/adr/sel
//   i_m1_*_nxt                cache next-cycle cyc/stb/wen/adr/dat/sel/cti/bte
//   o_m0_ack/err, o_m1_ack/err per-master completion, only to current owner
//   o_rdata                   slave read data passed through to both masters
//   o_wb_*                    registered slave-side Wishbone controls
//   i_wb_dat/ack/err          slave response
//   o_timeout                 one-cycle pulse when the watchdog aborts
// ---------------------------------------------------------------------------
module zap_wb_walk_arb #(
    parameter int unsigned WDT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_cyc_nxt,
    input  logic        i_m0_stb_nxt,
    input  logic [31:0] i_m0_adr_nxt,
    input  logic [3:0]  i_m0_sel_nxt,
    input  logic        i_m1_cyc_nxt,
    input  logic        i_m1_stb_nxt,
    input  logic        i_m1_wen_nxt,
    input  logic [31:0] i_m1_adr_nxt,
    input  logic [31:0] i_m1_dat_nxt,
    input  logic [3:0]  i_m1_sel_nxt,
    input  logic [2:0]  i_m1_cti_nxt,
    input  logic [1:0]  i_m1_bte_nxt,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    output logic [1:0]  o_wb_bte,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } bus_t;

    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;     // 0: page-walker, 1: cache; remembered for DRAIN
    logic        owner_s;
    bus_t        bus_r;
    bus_t        bus_s;
    bus_t        m0_bus_s;
    bus_t        m1_bus_s;
    logic [15:0] wdt_r;
    logic        granted_s;
    logic        expire_s;
    logic        owner_cyc_s;

    // Map each master's next-cycle request onto bus fields; the walker only
    // reads single beats, so its write/burst fields are fixed.
    always_comb begin
        m0_bus_s     = '0;
        m0_bus_s.cyc = i_m0_cyc_nxt;
        m0_bus_s.stb = i_m0_stb_nxt;
        m0_bus_s.wen = 1'b0;
        m0_bus_s.adr = i_m0_adr_nxt;
        m0_bus_s.dat = 32'h0000_0000;
        m0_bus_s.sel = i_m0_sel_nxt;
        m0_bus_s.cti = 3'b111;
        m0_bus_s.bte = 2'b00;

        m1_bus_s     = '0;
        m1_bus_s.cyc = i_m1_cyc_nxt;
        m1_bus_s.stb = i_m1_stb_nxt;
        m1_bus_s.wen = i_m1_wen_nxt;
        m1_bus_s.adr = i_m1_adr_nxt;
        m1_bus_s.dat = i_m1_dat_nxt;
        m1_bus_s.sel = i_m1_sel_nxt;
        m1_bus_s.cti = i_m1_cti_nxt;
        m1_bus_s.bte = i_m1_bte_nxt;
    end

    assign granted_s = (state_r == ST_GNT0) || (state_r == ST_GNT1);

    // An ack or err on the expiry cycle always wins over the watchdog.
    assign expire_s  = granted_s & bus_r.stb & ~i_wb_ack & ~i_wb_err &
                       (wdt_r == WDT_LAST);

    assign owner_cyc_s = owner_r ? i_m1_cyc_nxt : i_m0_cyc_nxt;

    // Next-state and next bus value; the bus is zero unless a master is
    // (or is becoming) the owner, which yields the idle cycle between owners.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        bus_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (i_m0_cyc_nxt) begin
                    state_s = ST_GNT0;
                    owner_s = 1'b0;
                    bus_s   = m0_bus_s;
                end else if (i_m1_cyc_nxt) begin
                    state_s = ST_GNT1;
                    owner_s = 1'b1;
                    bus_s   = m1_bus_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (expire_s) begin
                    state_s = ST_DRAIN;
                end else if (!i_m0_cyc_nxt) begin
                    state_s = ST_IDLE;
                end else begin
                    bus_s   = m0_bus_s;
                end
            end
            ST_GNT1: begin
                if (expire_s) begin
                    state_s = ST_DRAIN;
                end else if (!i_m1_cyc_nxt) begin
                    state_s = ST_IDLE;
                end else begin
                    bus_s   = m1_bus_s;
                end
            end
            ST_DRAIN: begin
                // Hold the bus quiet until the aborted master lets go.
                if (!owner_cyc_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, owner and registered bus outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            bus_r   <= '0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            bus_r   <= bus_s;
        end
    end

    // Stall watchdog: counts strobe cycles that get neither ack nor err.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wdt_r <= 16'd0;
        end else if (!bus_r.stb || i_wb_ack || i_wb_err || expire_s) begin
            wdt_r <= 16'd0;
        end else begin
            wdt_r <= wdt_r + 16'd1;
        end
    end

    assign o_wb_cyc  = bus_r.cyc;
    assign o_wb_stb  = bus_r.stb;
    assign o_wb_wen  = bus_r.wen;
    assign o_wb_adr  = bus_r.adr;
    assign o_wb_dat  = bus_r.dat;
    assign o_wb_sel  = bus_r.sel;
    assign o_wb_cti  = bus_r.cti;
    assign o_wb_bte  = bus_r.bte;

    assign o_rdata   = i_wb_dat;

    // Responses reach only the master that currently holds the grant.
    assign o_m0_ack  = i_wb_ack & bus_r.stb & (state_r == ST_GNT0);
    assign o_m1_ack  = i_wb_ack & bus_r.stb & (state_r == ST_GNT1);
    assign o_m0_err  = ((i_wb_err & bus_r.stb) | expire_s) & (state_r == ST_GNT0);
    assign o_m1_err  = ((i_wb_err & bus_r.stb) | expire_s) & (state_r == ST_GNT1);
    assign o_timeout = expire_s;

endmodule

// File: tb/tb_zap_wb_walk_arb.sv
// ---------------------------------------------------------------------------
// tb_zap_wb_walk_arb
// Directed scenarios followed by randomized traffic. A driver applies one
// stimulus vector per cycle, predicts every DUT output for that cycle from an
// ownership-level reference model and queues the prediction; a monitor on
// the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_zap_wb_walk_arb;

    localparam int WDT = 4;

    typedef struct packed {
        logic        m0_cyc;
        logic        m0_stb;
        logic [31:0] m0_adr;
        logic [3:0]  m0_sel;
        logic        m1_cyc;
        logic        m1_stb;
        logic        m1_wen;
        logic [31:0] m1_adr;
        logic [31:0] m1_dat;
        logic [3:0]  m1_sel;
        logic [2:0]  m1_cti;
        logic [1:0]  m1_bte;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
    } stim_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } bus_t;

    typedef struct packed {
        logic        m0_ack;
        logic        m0_err;
        logic        m1_ack;
        logic        m1_err;
        logic        timeout;
        logic [31:0] rdata;
        bus_t        bus;
    } obs_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_m0_cyc_nxt = 1'b0, i_m0_stb_nxt = 1'b0;
    logic [31:0] i_m0_adr_nxt = 32'h0;
    logic [3:0]  i_m0_sel_nxt = 4'h0;
    logic        i_m1_cyc_nxt = 1'b0, i_m1_stb_nxt = 1'b0, i_m1_wen_nxt = 1'b0;
    logic [31:0] i_m1_adr_nxt = 32'h0, i_m1_dat_nxt = 32'h0;
    logic [3:0]  i_m1_sel_nxt = 4'h0;
    logic [2:0]  i_m1_cti_nxt = 3'h0;
    logic [1:0]  i_m1_bte_nxt = 2'h0;
    logic [31:0] i_wb_dat = 32'h0;
    logic        i_wb_ack = 1'b0, i_wb_err = 1'b0;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_timeout;
    logic [31:0] o_rdata, o_wb_adr, o_wb_dat;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic [1:0]  o_wb_bte;

    always #5 i_clk = ~i_clk;

    zap_wb_walk_arb #(.WDT_CYCLES(WDT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_cyc_nxt(i_m0_cyc_nxt), .i_m0_stb_nxt(i_m0_stb_nxt),
        .i_m0_adr_nxt(i_m0_adr_nxt), .i_m0_sel_nxt(i_m0_sel_nxt),
        .i_m1_cyc_nxt(i_m1_cyc_nxt), .i_m1_stb_nxt(i_m1_stb_nxt),
        .i_m1_wen_nxt(i_m1_wen_nxt), .i_m1_adr_nxt(i_m1_adr_nxt),
        .i_m1_dat_nxt(i_m1_dat_nxt), .i_m1_sel_nxt(i_m1_sel_nxt),
        .i_m1_cti_nxt(i_m1_cti_nxt), .i_m1_bte_nxt(i_m1_bte_nxt),
        .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_rdata(o_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_cti(o_wb_cti), .o_wb_bte(o_wb_bte),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_timeout(o_timeout)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model: who owns the bus, whether the owner was aborted,
    // how long the current strobe has stalled, and what the bus shows.
    int   m_owner = -1;
    bit   m_drain = 1'b0;
    int   m_stall = 0;
    bus_t m_bus   = '0;

    function automatic bus_t bus_of(input int who, input stim_t s);
        bus_t b;
        b = '0;
        if (who == 0) begin
            b.cyc = s.m0_cyc; b.stb = s.m0_stb; b.adr = s.m0_adr;
            b.sel = s.m0_sel; b.cti = 3'b111;
        end else begin
            b.cyc = s.m1_cyc; b.stb = s.m1_stb; b.wen = s.m1_wen;
            b.adr = s.m1_adr; b.dat = s.m1_dat; b.sel = s.m1_sel;
            b.cti = s.m1_cti; b.bte = s.m1_bte;
        end
        return b;
    endfunction

    function automatic stim_t mk(input bit m0, input logic [31:0] a0,
                                 input bit m1, input logic [31:0] a1,
                                 input bit wen, input logic [2:0] cti,
                                 input bit ack, input bit err,
                                 input logic [31:0] rd);
        stim_t s;
        s = '0;
        s.m0_cyc = m0; s.m0_stb = m0; s.m0_adr = a0; s.m0_sel = 4'hF;
        s.m1_cyc = m1; s.m1_stb = m1; s.m1_wen = wen; s.m1_adr = a1;
        s.m1_dat = a1 ^ 32'hA5A5_0000; s.m1_sel = 4'hF; s.m1_cti = cti;
        s.ack = ack; s.err = err; s.rdat = rd;
        return s;
    endfunction

    // One bus cycle: drive, predict, queue prediction, advance the model.
    task automatic apply(input stim_t s, input bit rst);
        obs_t e;
        bit   gr;
        bit   expire;
        bit   owner_cyc;
        @(posedge i_clk);
        #1;
        i_m0_cyc_nxt = s.m0_cyc; i_m0_stb_nxt = s.m0_stb;
        i_m0_adr_nxt = s.m0_adr; i_m0_sel_nxt = s.m0_sel;
        i_m1_cyc_nxt = s.m1_cyc; i_m1_stb_nxt = s.m1_stb;
        i_m1_wen_nxt = s.m1_wen; i_m1_adr_nxt = s.m1_adr;
        i_m1_dat_nxt = s.m1_dat; i_m1_sel_nxt = s.m1_sel;
        i_m1_cti_nxt = s.m1_cti; i_m1_bte_nxt = s.m1_bte;
        i_wb_ack = s.ack; i_wb_err = s.err; i_wb_dat = s.rdat;
        i_reset_n = !rst;
        e = '0;
        e.rdata = s.rdat;
        if (rst) begin
            m_owner = -1; m_drain = 1'b0; m_stall = 0; m_bus = '0;
            exp_q.push_back(e);
        end else begin
            gr = (m_owner >= 0) && !m_drain;
            expire = gr && m_bus.stb && !s.ack && !s.err && (m_stall == WDT - 1);
            e.bus = m_bus;
            if (gr && m_bus.stb) begin
                if (m_owner == 0) begin
                    e.m0_ack = s.ack; e.m0_err = s.err;
                end else begin
                    e.m1_ack = s.ack; e.m1_err = s.err;
                end
            end
            if (expire) begin
                e.timeout = 1'b1;
                if (m_owner == 0) e.m0_err = 1'b1;
                else              e.m1_err = 1'b1;
            end
            exp_q.push_back(e);

            m_stall = (m_bus.stb && !s.ack && !s.err && !expire) ? m_stall + 1 : 0;
            owner_cyc = (m_owner == 0) ? s.m0_cyc : (m_owner == 1) ? s.m1_cyc : 1'b0;
            if (m_drain) begin
                m_bus = '0;
                if (!owner_cyc) begin
                    m_drain = 1'b0; m_owner = -1;
                end
            end else if (gr) begin
                if (expire) begin
                    m_drain = 1'b1; m_bus = '0;
                end else if (!owner_cyc) begin
                    m_owner = -1; m_bus = '0;
                end else begin
                    m_bus = bus_of(m_owner, s);
                end
            end else if (s.m0_cyc) begin
                m_owner = 0; m_bus = bus_of(0, s);
            end else if (s.m1_cyc) begin
                m_owner = 1; m_bus = bus_of(1, s);
            end else begin
                m_bus = '0;
            end
        end
    endtask

    // Monitor: compare every observed cycle against the queued prediction.
    always @(negedge i_clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_timeout, o_rdata,
                  '{o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_adr, o_wb_dat,
                    o_wb_sel, o_wb_cti, o_wb_bte}};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t ack0/err0/ack1/err1/to got %b%b%b%b%b want %b%b%b%b%b bus got %h want %h rdata got %h want %h",
                         $time, a.m0_ack, a.m0_err, a.m1_ack, a.m1_err, a.timeout,
                         e.m0_ack, e.m0_err, e.m1_ack, e.m1_err, e.timeout,
                         a.bus, e.bus, a.rdata, e.rdata);
            end
        end
    end

    initial begin
        stim_t s;
        bit    m0_on;
        bit    m1_on;
        m0_on = 1'b0;
        m1_on = 1'b0;

        // Reset held, then released with both masters quiet.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111), 1'b1);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h2222_2222), 1'b1);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h3333_3333), 1'b0);

        // Page-walker single read returning 0xDEADBEEF.
        apply(mk(1, 32'h0000_4008, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(1, 32'h0000_4008, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Simultaneous requests: walker first, then cache write to 0x100.
        for (int i = 0; i < 3; i++)
            apply(mk(1, 32'h10, 1, 32'h100, 1, 3'b111, i == 2, 0, 0), 1'b0);
        for (int i = 0; i < 4; i++)
            apply(mk(0, 0, 1, 32'h100, 1, 3'b111, i == 3, 0, 0), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Cache 4-beat incrementing burst while the walker keeps requesting.
        apply(mk(0, 0, 1, 32'h200, 0, 3'b010, 0, 0, 0), 1'b0);
        for (int b = 0; b < 4; b++)
            apply(mk(1, 32'h9000, b < 3, 32'h200 + 32'(4 * (b + 1)), 0,
                     (b >= 2) ? 3'b111 : 3'b010, 1, 0, 32'(b)), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Walker strobe never answered: watchdog abort, drain, release.
        for (int i = 0; i < 8; i++)
            apply(mk(1, 32'h7000, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Ack lands exactly on the expiry cycle: ack wins, grant kept.
        for (int i = 0; i < 6; i++)
            apply(mk(1, 32'h7100, 0, 0, 0, 0, i == 4, 0, 32'h55AA_55AA), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Reset during cache burst beat 2; walker pending wins afterwards.
        apply(mk(0, 0, 1, 32'h300, 0, 3'b010, 0, 0, 0), 1'b0);
        apply(mk(1, 32'h500, 1, 32'h304, 0, 3'b010, 1, 0, 0), 1'b0);
        apply(mk(1, 32'h500, 1, 32'h308, 0, 3'b010, 0, 0, 0), 1'b1);
        apply(mk(1, 32'h500, 1, 32'h308, 0, 3'b010, 0, 0, 0), 1'b0);
        apply(mk(1, 32'h500, 1, 32'h308, 0, 3'b010, 1, 0, 0), 1'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Randomized traffic with persistent master activity.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) m0_on = !m0_on;
            if ($urandom_range(0, 9) == 0) m1_on = !m1_on;
            s = '0;
            s.m0_cyc = m0_on;
            s.m0_stb = m0_on && ($urandom_range(0, 4) != 0);
            s.m0_adr = $urandom;
            s.m0_sel = 4'($urandom);
            s.m1_cyc = m1_on;
            s.m1_stb = m1_on && ($urandom_range(0, 4) != 0);
            s.m1_wen = 1'($urandom);
            s.m1_adr = $urandom;
            s.m1_dat = $urandom;
            s.m1_sel = 4'($urandom);
            s.m1_cti = 3'($urandom);
            s.m1_bte = 2'($urandom);
            s.ack    = ($urandom_range(0, 3) == 0);
            s.err    = ($urandom_range(0, 19) == 0);
            s.rdat   = $urandom;
            apply(s, $urandom_range(0, 299) == 0);
        end

        @(posedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
